// File: rtl/mb_rtu_frame_rx.sv
// ============================================================================
//  Module   : mb_rtu_frame_rx
//  Purpose  : Modbus RTU frame receiver. Delimits frames by line silence
//             (T1.5 / T3.5), buffers the bytes, filters on station address,
//             optionally verifies CRC-16, and reports one verdict per frame.
//  Options  : define MB_CRC_CHECK_EN to build in the CRC-16 check.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mb_rtu_frame_rx #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 9600,
    parameter int MAX_LEN   = 64
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    input  logic [7:0]                   rx_data,
    input  logic                         rx_done,
    input  logic [7:0]                   slave_addr,
    input  logic [$clog2(MAX_LEN)-1:0]   rd_addr,
    output logic [7:0]                   rd_data,
    output logic                         frame_done,
    output logic                         frame_ok,
    output logic [1:0]                   err_code,
    output logic [$clog2(MAX_LEN):0]     frame_len,
    output logic                         is_bcast,
    output logic                         busy
);

    localparam int AW  = $clog2(MAX_LEN);
    // Above 19200 baud the standard fixes the silence intervals in time.
    localparam int T15 = (BAUD_RATE > 19200) ?
                         int'((64'(CLK_FREQ) * 64'd750) / 64'd1000000) :
                         int'((64'(CLK_FREQ) * 64'd33) / (64'd2 * 64'(BAUD_RATE)));
    localparam int T35 = (BAUD_RATE > 19200) ?
                         int'((64'(CLK_FREQ) * 64'd1750) / 64'd1000000) :
                         int'((64'(CLK_FREQ) * 64'd77) / (64'd2 * 64'(BAUD_RATE)));
    localparam int TW  = $clog2(T35 + 1);

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_IDLE    = 3'd1,
        ST_RECV    = 3'd2,
        ST_GAP     = 3'd3,
        ST_CHECK   = 3'd4,
        ST_DISCARD = 3'd5
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [TW-1:0]   timer;
    logic [AW:0]     count;
    logic [7:0]      addr_byte;
    logic [1:0]      err_latch;
    logic [7:0]      mem [0:MAX_LEN-1];

    logic            start_frame;
    logic            store_byte;
    logic            overrun;
    logic            check_now;
    logic            discard_end;
    logic            t15_hit;
    logic            t35_hit;
    logic            addr_match;
    logic            crc_bad;
    logic            buf_we;
    logic [AW-1:0]   buf_idx;

    assign t15_hit    = (timer >= TW'(T15));
    assign t35_hit    = (timer >= TW'(T35));
    assign addr_match = (addr_byte == slave_addr) || (addr_byte == 8'h00);
    assign busy       = (state != ST_IDLE);
    assign buf_we     = start_frame | store_byte;
    assign buf_idx    = start_frame ? '0 : count[AW-1:0];

`ifdef MB_CRC_CHECK_EN
    logic [15:0] crc;

    // One whole byte of reflected CRC-16 (poly 0xA001) per call.
    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {8'h00, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        end
        return r;
    endfunction

    // Running CRC over every stored byte, CRC bytes included (residual 0 = good).
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            crc <= 16'hFFFF;
        end else if (start_frame) begin
            crc <= crc16_byte(16'hFFFF, rx_data);
        end else if (store_byte) begin
            crc <= crc16_byte(crc, rx_data);
        end
    end

    assign crc_bad = (crc != 16'h0000);
`else
    assign crc_bad = 1'b0;
`endif

    // Silence timer: restarted by every byte, saturates at T3.5.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            timer <= '0;
        end else if (rx_done) begin
            timer <= '0;
        end else if (!t35_hit) begin
            timer <= timer + 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state <= ST_INIT;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and control decode; a byte always wins over a timer threshold.
    always_comb begin
        next_state  = state;
        start_frame = 1'b0;
        store_byte  = 1'b0;
        overrun     = 1'b0;
        check_now   = 1'b0;
        discard_end = 1'b0;
        case (state)
            ST_INIT: begin
                if (!rx_done && t35_hit) next_state = ST_IDLE;
            end
            ST_IDLE: begin
                if (rx_done) begin
                    start_frame = 1'b1;
                    next_state  = ST_RECV;
                end
            end
            ST_RECV: begin
                if (rx_done) begin
                    if (count < (AW+1)'(MAX_LEN)) begin
                        store_byte = 1'b1;
                    end else begin
                        overrun    = 1'b1;
                        next_state = ST_DISCARD;
                    end
                end else if (t15_hit) begin
                    next_state = ST_GAP;
                end
            end
            ST_GAP: begin
                if (rx_done) begin
                    overrun    = 1'b1;
                    next_state = ST_DISCARD;
                end else if (t35_hit) begin
                    next_state = ST_CHECK;
                end
            end
            ST_CHECK: begin
                check_now  = 1'b1;
                next_state = ST_IDLE;
            end
            ST_DISCARD: begin
                if (!rx_done && t35_hit) begin
                    discard_end = 1'b1;
                    next_state  = ST_IDLE;
                end
            end
            default: next_state = ST_INIT;
        endcase
    end

    // Frame bookkeeping: byte count, address byte and latched error.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            count     <= '0;
            addr_byte <= 8'h00;
            err_latch <= 2'd0;
        end else begin
            if (start_frame) begin
                count     <= (AW+1)'(1);
                addr_byte <= rx_data;
                err_latch <= 2'd0;
            end else if (store_byte) begin
                count <= count + 1'b1;
            end
            if (overrun) err_latch <= 2'd3;
        end
    end

    // Frame buffer storage; deliberately not cleared by reset.
    always_ff @(posedge clk_in) begin
        if (buf_we) mem[buf_idx] <= rx_data;
    end

    // Registered buffer read port.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            rd_data <= 8'h00;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

    // Verdict outputs: change only together with the frame_done pulse.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            err_code   <= 2'd0;
            frame_len  <= '0;
            is_bcast   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (check_now) begin
                if (count < (AW+1)'(4)) begin
                    frame_done <= 1'b1;
                    frame_ok   <= 1'b0;
                    err_code   <= 2'd2;
                    frame_len  <= count;
                    is_bcast   <= 1'b0;
                end else if (addr_match) begin
                    // Frames for other stations are dropped without a verdict.
                    frame_done <= 1'b1;
                    frame_len  <= count;
                    if (crc_bad) begin
                        frame_ok <= 1'b0;
                        err_code <= 2'd1;
                        is_bcast <= 1'b0;
                    end else begin
                        frame_ok <= 1'b1;
                        err_code <= 2'd0;
                        is_bcast <= (addr_byte == 8'h00);
                    end
                end
            end else if (discard_end) begin
                frame_done <= 1'b1;
                frame_ok   <= 1'b0;
                err_code   <= err_latch;
                frame_len  <= count;
                is_bcast   <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/mb_rtu_frame_rx.md
MB_RTU_FRAME_RX -- requirements
Module: mb_rtu_frame_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, serial line rate in bit/s.
REQ-003 SHALL have parameter MAX_LEN, default 64, frame buffer depth in bytes (power of two, 8..256).
REQ-004 SHALL have port clk_in  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n_in  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port rx_data  input  8  received byte, valid while rx_done=1.
REQ-007 SHALL have port rx_done  input  1  one-cycle pulse, one received byte.
REQ-008 SHALL have port slave_addr  input  8  own station address, sampled in CHECK.
REQ-009 SHALL have port rd_addr  input  log2(MAX_LEN)  buffer read address.
REQ-010 SHALL have port rd_data  output  8  buffer byte at rd_addr, registered.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse, frame verdict valid.
REQ-012 SHALL have port frame_ok  output  1  1 = frame accepted, no error.
REQ-013 SHALL have port err_code  output  2  0 none, 1 CRC, 2 short (<4 bytes), 3 overrun/inter-char gap.
REQ-014 SHALL have port frame_len  output  log2(MAX_LEN)+1  byte count including CRC.
REQ-015 SHALL have port is_bcast  output  1  accepted frame had address 0x00.
REQ-016 SHALL have port busy  output  1  high in any state except IDLE.

Function
REQ-017 SHALL define T15 = CLK_FREQ*33/(2*BAUD_RATE) and T35 = CLK_FREQ*77/(2*BAUD_RATE) cycles; for BAUD_RATE>19200, T15 = CLK_FREQ*750/1e6 and T35 = CLK_FREQ*1750/1e6.
REQ-018 SHALL keep one silence timer: cleared on every rx_done, otherwise incremented, saturating at T35.
REQ-019 SHALL implement states INIT, IDLE, RECV, GAP, CHECK, DISCARD.
REQ-020 INIT: timer reaching T35 -> IDLE; bytes received in INIT are ignored.
REQ-021 IDLE: rx_done -> write byte at index 0, count=1, CRC=0xFFFF updated with byte -> RECV.
REQ-022 RECV: rx_done with count<MAX_LEN -> write byte at index count, count+1, update CRC; rx_done with count==MAX_LEN -> DISCARD, err_code 3; timer reaching T15 -> GAP.
REQ-023 GAP: rx_done -> DISCARD, err_code 3; timer reaching T35 -> CHECK.
REQ-024 CHECK (exactly one cycle, then IDLE): count<4 -> verdict err 2; else address byte neither slave_addr nor 0x00 -> no frame_done (silent drop); else CRC residual !=0 -> err 1; else frame_ok=1.
REQ-025 DISCARD: rx_done restarts timer; timer reaching T35 -> IDLE with frame_done=1, frame_ok=0, err_code as latched.
REQ-026 CRC SHALL be Modbus CRC-16 (reflected polynomial 0xA001, init 0xFFFF), processed one full byte per rx_done, over all bytes including the 2 CRC bytes; a valid frame leaves residual 0x0000.
REQ-027 frame_ok, err_code, frame_len, is_bcast SHALL update only in the cycle frame_done is high and hold until the next frame_done.
REQ-028 rd_data SHALL equal buffer[rd_addr] one cycle after rd_addr is presented; contents remain stable from frame_done until the next IDLE->RECV transition.
REQ-029 Simultaneous rx_done and timer threshold in the same cycle: rx_done takes precedence.

Reset
REQ-030 On rst_n_in=0 at a clock edge: state INIT, timer 0, count 0, CRC 0xFFFF, frame_done 0, frame_ok 0, err_code 0, frame_len 0, is_bcast 0, rd_data 0; buffer contents are not cleared.
REQ-031 Reset asserted mid-frame SHALL abandon the frame with no frame_done.

Configuration
REQ-032 With macro MB_CRC_CHECK_EN defined, CRC SHALL be computed and checked per REQ-026.
REQ-033 Without MB_CRC_CHECK_EN, no CRC logic SHALL be present, err_code 1 SHALL never occur, and frames passing length and address checks are accepted.

Verification (bench may override CLK_FREQ=1000000 for run time)
REQ-034 slave_addr=0x11, bytes 11 03 00 6B 00 03 76 87 at nominal spacing, then silence -> frame_done once after T35, frame_ok=1, frame_len=8, err_code 0, rd_addr 0..7 returns the same bytes.
REQ-035 Same frame with last byte 0x88 -> frame_ok=0, err_code 1 (frame_ok=1 without MB_CRC_CHECK_EN).
REQ-036 Frame addressed 0x12 -> no frame_done; frame addressed 0x00 with valid CRC -> frame_ok=1, is_bcast=1.
REQ-037 Gap of T15+10 cycles between bytes 3 and 4 -> DISCARD, single frame_done with err_code 3 after final T35 silence.
REQ-038 MAX_LEN+1 bytes back-to-back -> err_code 3; 3-byte frame -> err_code 2.
REQ-039 Reset pulsed after byte 4 of a frame -> no frame_done; bytes before T35 silence ignored; next clean frame accepted.
